// File: rtl/sram8_ctrl.sv
// sram8_ctrl: single-beat valid/ready bus controller for an 8-bit asynchronous
// SRAM with a shared bidirectional data bus. Each access runs through setup,
// strobe and hold phases. Writes add a bus-turnaround gap before the next request.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; cs low, address holds last value
// SETUP  | address and cs asserted; write data driven one cycle ahead
// STROBE | we (write) or oe (read) asserted for WAIT_CYCLES cycles
// HOLD   | strobe released, cs/address/data held; completion pulse
// TURN   | after writes only: cs low, bus released for TURN_CYCLES cycles
module sram8_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic        wr_done_o,
    output logic [15:0] sram_addr_o,
    inout  wire  [7:0]  sram_data_io,
    output logic        sram_cs_o,
    output logic        sram_oe_o,
    output logic        sram_we_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_TURN   = 3'd4;

    // Down-counters reload with (length - 1) and the phase ends at zero.
    localparam logic [3:0] W_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] T_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdy_q, rdy_d;
    logic        cs_q, cs_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        drv_q, drv_d;
    logic        rsp_q, rsp_d;
    logic        wrd_q, wrd_d;

    // Next-state logic; every pin value is derived from the state being entered
    // so all outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rsp_d   = 1'b0;
        wrd_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // rdy_q gates acceptance so nothing is taken on the first cycle out of reset.
                if (req_valid_i && rdy_q) begin
                    is_wr_d = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = W_LOAD;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    if (is_wr_q) begin
                        wrd_d = 1'b1;
                    end else begin
                        rdata_d = sram_data_io;
                        rsp_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (is_wr_q && (TURN_CYCLES > 0)) begin
                    cnt_d   = T_LOAD;
                    state_d = S_TURN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rdy_d = (state_d == S_IDLE);
        cs_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        we_d  = (state_d == S_STROBE) && is_wr_d;
        oe_d  = (state_d == S_STROBE) && !is_wr_d;
        drv_d = cs_d && is_wr_d;
    end

    // State and output registers; reset clears the pins and releases the bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            is_wr_q <= 1'b0;
            wdata_q <= 8'h00;
            addr_q  <= 16'h0000;
            rdata_q <= 8'h00;
            rdy_q   <= 1'b0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            drv_q   <= 1'b0;
            rsp_q   <= 1'b0;
            wrd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            drv_q   <= drv_d;
            rsp_q   <= rsp_d;
            wrd_q   <= wrd_d;
        end
    end

    assign sram_data_io = drv_q ? wdata_q : 8'bzzzz_zzzz;
    assign req_ready_o  = rdy_q;
    assign rsp_valid_o  = rsp_q;
    assign rsp_rdata_o  = rdata_q;
    assign wr_done_o    = wrd_q;
    assign sram_addr_o  = addr_q;
    assign sram_cs_o    = cs_q;
    assign sram_oe_o    = oe_q;
    assign sram_we_o    = we_q;

endmodule

// File: tb/tb_sram8_ctrl.sv
// Directed bench for sram8_ctrl: two instances (W=2/T=1 and W=1/T=0), each with
// a small async-SRAM model on a pulled-up data bus. A released bus reads 0xFF.
module tb_sram8_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int mon_err  = 0;
    int n;

    logic        a_valid = 1'b0, a_we_req = 1'b0;
    logic [15:0] a_raddr = 16'h0;
    logic [7:0]  a_wdata = 8'h0;
    logic        a_rdy, a_rsp, a_wrd, a_cs, a_oe, a_we;
    logic [7:0]  a_rdata;
    logic [15:0] a_addr;
    wire  [7:0]  a_data;

    logic        b_valid = 1'b0, b_we_req = 1'b0;
    logic [15:0] b_raddr = 16'h0;
    logic [7:0]  b_wdata = 8'h0;
    logic        b_rdy, b_rsp, b_wrd, b_cs, b_oe, b_we;
    logic [7:0]  b_rdata;
    logic [15:0] b_addr;
    wire  [7:0]  b_data;

    sram8_ctrl #(.WAIT_CYCLES(2), .TURN_CYCLES(1)) u_a (
        .clk(clk), .rst(rst),
        .req_valid_i(a_valid), .req_ready_o(a_rdy), .req_we_i(a_we_req),
        .req_addr_i(a_raddr), .req_wdata_i(a_wdata),
        .rsp_valid_o(a_rsp), .rsp_rdata_o(a_rdata), .wr_done_o(a_wrd),
        .sram_addr_o(a_addr), .sram_data_io(a_data),
        .sram_cs_o(a_cs), .sram_oe_o(a_oe), .sram_we_o(a_we)
    );

    sram8_ctrl #(.WAIT_CYCLES(1), .TURN_CYCLES(0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid_i(b_valid), .req_ready_o(b_rdy), .req_we_i(b_we_req),
        .req_addr_i(b_raddr), .req_wdata_i(b_wdata),
        .rsp_valid_o(b_rsp), .rsp_rdata_o(b_rdata), .wr_done_o(b_wrd),
        .sram_addr_o(b_addr), .sram_data_io(b_data),
        .sram_cs_o(b_cs), .sram_oe_o(b_oe), .sram_we_o(b_we)
    );

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (a_data[g]);
        pullup (b_data[g]);
    end

    // SRAM models: drive when selected and read-enabled; a write commits only
    // when the strobe ends with cs still high, so an aborted write is lost.
    logic [7:0]  mem_a [0:65535];
    logic [7:0]  mem_b [0:65535];
    logic        a_pend = 1'b0, b_pend = 1'b0;
    logic [15:0] a_paddr, b_paddr;
    logic [7:0]  a_pdata, b_pdata;

    assign a_data = (a_cs && a_oe && !a_we) ? mem_a[a_addr] : 8'bzzzz_zzzz;
    assign b_data = (b_cs && b_oe && !b_we) ? mem_b[b_addr] : 8'bzzzz_zzzz;

    always @(posedge clk) begin
        if (a_cs && a_we) begin
            a_pend <= 1'b1; a_paddr <= a_addr; a_pdata <= a_data;
        end else if (a_pend) begin
            if (a_cs) mem_a[a_paddr] <= a_pdata;
            a_pend <= 1'b0;
        end
        if (b_cs && b_we) begin
            b_pend <= 1'b1; b_paddr <= b_addr; b_pdata <= b_data;
        end else if (b_pend) begin
            if (b_cs) mem_b[b_paddr] <= b_pdata;
            b_pend <= 1'b0;
        end
    end

    // Bus protocol monitor: we/oe exclusive, strobes only under cs.
    always @(negedge clk) begin
        if (!rst) begin
            if ((a_we && a_oe) || ((a_we || a_oe) && !a_cs)) mon_err++;
            if ((b_we && b_oe) || ((b_we || b_oe) && !b_cs)) mon_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic        op_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] op_addr [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    logic [7:0]  op_data [4] = '{8'hC3, 8'hC3, 8'h69, 8'h69};

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_ready", a_rdy, 1'b0);
        chk("rst_cs", a_cs, 1'b0);
        chk("rst_oe", a_oe, 1'b0);
        chk("rst_we", a_we, 1'b0);
        chk("rst_data_released", a_data, 8'hFF);
        chk("rst_rdata", a_rdata, 8'h00);
        chk("rst_addr", a_addr, 16'h0000);
        chk("rst_rsp", a_rsp, 1'b0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", a_rdy, 1'b1);

        // A: write 0x1234 <= 0xA5, cycle by cycle
        a_valid = 1'b1; a_we_req = 1'b1; a_raddr = 16'h1234; a_wdata = 8'hA5;
        step(); a_valid = 1'b0;
        chk("wr_c1_addr", a_addr, 16'h1234);
        chk("wr_c1_cs", a_cs, 1'b1);
        chk("wr_c1_we", a_we, 1'b0);
        chk("wr_c1_data", a_data, 8'hA5);
        step();
        chk("wr_c2_we", a_we, 1'b1);
        chk("wr_c2_data", a_data, 8'hA5);
        step();
        chk("wr_c3_we", a_we, 1'b1);
        step();
        chk("wr_c4_we", a_we, 1'b0);
        chk("wr_c4_done", a_wrd, 1'b1);
        chk("wr_c4_cs", a_cs, 1'b1);
        chk("wr_c4_data", a_data, 8'hA5);
        chk("wr_c4_ready", a_rdy, 1'b0);
        step();
        chk("wr_c5_done", a_wrd, 1'b0);
        chk("wr_c5_cs", a_cs, 1'b0);
        chk("wr_c5_data_released", a_data, 8'hFF);
        chk("wr_c5_ready", a_rdy, 1'b0);
        chk("wr_c5_addr_held", a_addr, 16'h1234);
        step();
        chk("wr_c6_ready", a_rdy, 1'b1);
        chk("wr_commit", mem_a[16'h1234], 8'hA5);

        // A: read 0x1234
        a_valid = 1'b1; a_we_req = 1'b0; a_raddr = 16'h1234; a_wdata = 8'h5A;
        step(); a_valid = 1'b0;
        chk("rd_c1_cs", a_cs, 1'b1);
        chk("rd_c1_oe", a_oe, 1'b0);
        chk("rd_c1_data_released", a_data, 8'hFF);
        step();
        chk("rd_c2_oe", a_oe, 1'b1);
        chk("rd_c2_bus", a_data, 8'hA5);
        step();
        chk("rd_c3_oe", a_oe, 1'b1);
        chk("rd_c3_rsp", a_rsp, 1'b0);
        step();
        chk("rd_c4_oe", a_oe, 1'b0);
        chk("rd_c4_rsp", a_rsp, 1'b1);
        chk("rd_c4_rdata", a_rdata, 8'hA5);
        step();
        chk("rd_c5_rsp", a_rsp, 1'b0);
        chk("rd_c5_ready", a_rdy, 1'b1);
        chk("rd_c5_rdata_held", a_rdata, 8'hA5);

        // A: valid held, alternating write/read at the address extremes
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_we_req = op_we[i]; a_raddr = op_addr[i];
            a_wdata  = op_we[i] ? op_data[i] : 8'h5A;
            n = 0;
            while (!a_rdy && n < 30) begin step(); n++; end
            chk("stream_ready", a_rdy, 1'b1);
            step();
            if (!op_we[i]) begin
                n = 0;
                while (!a_rsp && n < 30) begin step(); n++; end
                chk("stream_rsp", a_rsp, 1'b1);
                chk("stream_rdata", a_rdata, op_data[i]);
            end
        end
        a_valid = 1'b0;

        // B (W=1, T=0): write then read back-to-back
        b_valid = 1'b1; b_we_req = 1'b1; b_raddr = 16'h0100; b_wdata = 8'h3C;
        step();
        b_we_req = 1'b0; b_wdata = 8'h5A;
        n = 0;
        while (!b_rdy && n < 20) begin step(); n++; end
        chk("b_accept_gap", 32'(1 + n), 32'd4);
        step(); b_valid = 1'b0;
        n = 0;
        while (!b_rsp && n < 20) begin step(); n++; end
        chk("b_rsp_latency", 32'(1 + n), 32'd3);
        chk("b_rdata", b_rdata, 8'h3C);

        // A: write 0x0042 <= 0x11, then abort a write of 0x77 mid-strobe
        n = 0;
        while (!a_rdy && n < 30) begin step(); n++; end
        a_valid = 1'b1; a_we_req = 1'b1; a_raddr = 16'h0042; a_wdata = 8'h11;
        step(); a_valid = 1'b0;
        n = 0;
        while (!a_rdy && n < 30) begin step(); n++; end
        chk("abort_pre_ready", a_rdy, 1'b1);
        a_valid = 1'b1; a_wdata = 8'h77;
        step(); a_valid = 1'b0;
        step();
        chk("abort_we_before", a_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_we_drop", a_we, 1'b0);
        chk("abort_cs_drop", a_cs, 1'b0);
        chk("abort_data_released", a_data, 8'hFF);
        step();
        chk("abort_no_wr_done", a_wrd, 1'b0);
        rst = 1'b0;
        step();
        chk("abort_ready_after", a_rdy, 1'b1);
        chk("abort_no_commit", mem_a[16'h0042], 8'h11);
        a_valid = 1'b1; a_we_req = 1'b0; a_wdata = 8'h5A;
        step(); a_valid = 1'b0;
        n = 0;
        while (!a_rsp && n < 30) begin step(); n++; end
        chk("abort_readback_rsp", a_rsp, 1'b1);
        chk("abort_readback", a_rdata, 8'h11);

        step();
        chk("bus_monitor", mon_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
